mux4_rr_arbiter: RTL and testbench

- Round-robin arbiter and select sequencer for the gate-level 4:1 multiplexer (inputs a, b, c, d; selects s0, s1; output w).
- Four requesters compete for the shared mux output. The block picks one owner, drives s1/s0 to route that owner's input to w, bounds ownership time, and inserts a guard cycle between owners.
- Sits directly in front of the mux select pins.

---
 rtl/mux4_rr_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
//   Round-robin arbiter and select sequencer placed directly in front of the
//   select pins of a 4:1 mux (inputs a,b,c,d -> requesters 0..3). It picks one
//   owner, routes that owner's input via {s1,s0}, limits how long an owner may
//   hold the mux, and inserts GAP_CYCLES guard cycles between owners.
//
// Parameters
//   HOLD_MAX   : max consecutive cycles per owner (1..15)
//   GAP_CYCLES : zero-grant guard cycles between owners (0..3)
//
// Ports
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   req   : request vector, bit i = requester i
//   grant : registered one-hot grant, zero when no owner
//   s0/s1 : registered mux select = owner index (held frozen when no owner)
//   busy  : high while owning or in the guard gap
//
// Optional feature
//   MUX_ARB_PRIO_EN : when defined, requester 0 wins every arbitration it takes
//                     part in; requesters 1..3 rotate among themselves.

module mux4_rr_arbiter #(
   parameter int unsigned HOLD_MAX   = 4,
   parameter int unsigned GAP_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   output logic [3:0] grant,
   output logic       s0,
   output logic       s1,
   output logic       busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN  = 2'd1,
      ST_GAP  = 2'd2
   } state_e;

   localparam logic [3:0] HOLD_MAX_C = 4'(HOLD_MAX);
   localparam logic [1:0] GAP_C      = 2'(GAP_CYCLES);

   state_e      state_q, state_d;
   logic [3:0]  grant_q, grant_d;
   logic [1:0]  sel_q,   sel_d;
   logic        busy_q,  busy_d;
   logic [1:0]  last_q,  last_d;
   logic [3:0]  hold_q,  hold_d;
   logic [1:0]  gap_q,   gap_d;

   // Arbitration result for the current edge
   logic [1:0]  arb_last;
   logic [3:0]  arb_req;
   logic        arb_found;
   logic [1:0]  arb_idx;
   logic [1:0]  cand;

   // When an owner is leaving with no gap, the pointer used for the same-edge
   // arbitration must already be that owner, before last_q catches up.
   assign arb_last = (state_q == ST_OWN) ? sel_q : last_q;

   always_comb begin
      arb_found = 1'b0;
      arb_idx   = arb_last;
      cand      = '0;
      arb_req   = req;
`ifdef MUX_ARB_PRIO_EN
      if (req[0]) begin
         arb_found = 1'b1;
         arb_idx   = 2'd0;
      end
      arb_req = {req[3:1], 1'b0};
`endif
      // Circular search starting at last+1; i=4 wraps back to last itself
      for (int unsigned i = 1; i <= 4; i++) begin
         cand = arb_last + 2'(i);
         if (!arb_found && arb_req[cand]) begin
            arb_found = 1'b1;
            arb_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      sel_d   = sel_q;
      busy_d  = busy_q;
      last_d  = last_q;
      hold_d  = hold_q;
      gap_d   = gap_q;

      unique case (state_q)
         ST_IDLE, ST_GAP: begin
            if (state_q == ST_GAP && gap_q < GAP_C) begin
               gap_d = gap_q + 2'd1;
            end else if (arb_found) begin
               state_d = ST_OWN;
               grant_d = 4'b0001 << arb_idx;
               sel_d   = arb_idx;
               busy_d  = 1'b1;
               hold_d  = 4'd1;
            end else begin
               state_d = ST_IDLE;
               grant_d = '0;
               busy_d  = 1'b0;
            end
         end

         ST_OWN: begin
            if (req[sel_q] && hold_q < HOLD_MAX_C) begin
               hold_d = hold_q + 4'd1;
            end else begin
               last_d  = sel_q;
               grant_d = '0;
               if (GAP_CYCLES != 0) begin
                  state_d = ST_GAP;
                  gap_d   = 2'd1;
               end else if (arb_found) begin
                  grant_d = 4'b0001 << arb_idx;
                  sel_d   = arb_idx;
                  hold_d  = 4'd1;
               end else begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         sel_q   <= '0;
         busy_q  <= 1'b0;
         last_q  <= 2'd3;
         hold_q  <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         sel_q   <= sel_d;
         busy_q  <= busy_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
         gap_q   <= gap_d;
      end
   end

   assign grant = grant_q;
   assign s0    = sel_q[0];
   assign s1    = sel_q[1];
   assign busy  = busy_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Testbench for mux4_rr_arbiter. Two instances: A (HOLD_MAX=4, GAP_CYCLES=1)
// and B (HOLD_MAX=1, GAP_CYCLES=0). Expected values are hand-computed.

module tb_mux4_rr_arbiter;

   typedef struct {
      logic [3:0] req;
      logic [3:0] grant;
      logic [1:0] sel;
      logic       busy;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_a, rst_b;
   logic [3:0] req_a, req_b;
   logic [3:0] grant_a, grant_b;
   logic       s0_a, s1_a, busy_a, s0_b, s1_b, busy_b;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mux4_rr_arbiter #(.HOLD_MAX(4), .GAP_CYCLES(1)) u_dut_a (
      .clk(clk), .rst(rst_a), .req(req_a),
      .grant(grant_a), .s0(s0_a), .s1(s1_a), .busy(busy_a)
   );

   mux4_rr_arbiter #(.HOLD_MAX(1), .GAP_CYCLES(0)) u_dut_b (
      .clk(clk), .rst(rst_b), .req(req_b),
      .grant(grant_b), .s0(s0_b), .s1(s1_b), .busy(busy_b)
   );

   task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got grant/sel/busy=%b_%b_%b expected %b_%b_%b", name,
                  act[6:3], act[2:1], act[0], exp[6:3], exp[2:1], exp[0]);
      end
   endtask

   task automatic step_a(input vec_t v, input string name);
      req_a = v.req;
      @(posedge clk);
      #1;
      check(name, {grant_a, s1_a, s0_a, busy_a}, {v.grant, v.sel, v.busy});
   endtask

   task automatic step_b(input vec_t v, input string name);
      req_b = v.req;
      @(posedge clk);
      #1;
      check(name, {grant_b, s1_b, s0_b, busy_b}, {v.grant, v.sel, v.busy});
   endtask

   // Structural invariants on both instances, checked every cycle
   always @(negedge clk) begin
      n_checks += 2;
      if (!$onehot0(grant_a) || (grant_a != 4'b0 && grant_a != (4'b0001 << {s1_a, s0_a}))) begin
         n_fail++;
         $display("FAIL inv_a: got grant=%b sel=%b%b required one-hot matching sel", grant_a, s1_a, s0_a);
      end
      if (!$onehot0(grant_b) || (grant_b != 4'b0 && grant_b != (4'b0001 << {s1_b, s0_b}))) begin
         n_fail++;
         $display("FAIL inv_b: got grant=%b sel=%b%b required one-hot matching sel", grant_b, s1_b, s0_b);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t tab_a[$];
      vec_t tab_b[$];
      vec_t tab_p[$];

      // Instance A from reset (pointer 3): {req, grant, sel, busy}
      tab_a.push_back('{4'b0000, 4'b0000, 2'b00, 1'b0});
      tab_a.push_back('{4'b0100, 4'b0100, 2'b10, 1'b1});  // 1-cycle latency
      tab_a.push_back('{4'b0000, 4'b0000, 2'b10, 1'b1});  // drop -> gap
      tab_a.push_back('{4'b0000, 4'b0000, 2'b10, 1'b0});  // idle, sel frozen
      for (int k = 0; k < 4; k++) tab_a.push_back('{4'b1111, 4'b1000, 2'b11, 1'b1});
      tab_a.push_back('{4'b1111, 4'b0000, 2'b11, 1'b1});
      for (int k = 0; k < 4; k++) tab_a.push_back('{4'b1111, 4'b0001, 2'b00, 1'b1});
      tab_a.push_back('{4'b1111, 4'b0000, 2'b00, 1'b1});
      for (int k = 0; k < 4; k++) tab_a.push_back('{4'b1111, 4'b0010, 2'b01, 1'b1});
      tab_a.push_back('{4'b1111, 4'b0000, 2'b01, 1'b1});
      for (int k = 0; k < 4; k++) tab_a.push_back('{4'b1111, 4'b0100, 2'b10, 1'b1});
      tab_a.push_back('{4'b1111, 4'b0000, 2'b10, 1'b1});
      tab_a.push_back('{4'b0010, 4'b0010, 2'b01, 1'b1});  // req changed in gap
      tab_a.push_back('{4'b0000, 4'b0000, 2'b01, 1'b1});
      tab_a.push_back('{4'b0010, 4'b0010, 2'b01, 1'b1});  // sole requester wraps
      tab_a.push_back('{4'b0011, 4'b0010, 2'b01, 1'b1});  // no preemption
      tab_a.push_back('{4'b0010, 4'b0010, 2'b01, 1'b1});
      tab_a.push_back('{4'b0010, 4'b0010, 2'b01, 1'b1});
      tab_a.push_back('{4'b0010, 4'b0000, 2'b01, 1'b1});
      tab_a.push_back('{4'b0010, 4'b0010, 2'b01, 1'b1});

      // Instance B: HOLD_MAX=1, no gap
`ifdef MUX_ARB_PRIO_EN
      tab_b.push_back('{4'b0011, 4'b0001, 2'b00, 1'b1});
      tab_b.push_back('{4'b0011, 4'b0001, 2'b00, 1'b1});
      tab_b.push_back('{4'b0011, 4'b0001, 2'b00, 1'b1});
`else
      tab_b.push_back('{4'b0011, 4'b0001, 2'b00, 1'b1});
      tab_b.push_back('{4'b0011, 4'b0010, 2'b01, 1'b1});  // direct handover
      tab_b.push_back('{4'b0011, 4'b0001, 2'b00, 1'b1});
`endif
      tab_b.push_back('{4'b0000, 4'b0000, 2'b00, 1'b0});
      tab_b.push_back('{4'b1000, 4'b1000, 2'b11, 1'b1});
      tab_b.push_back('{4'b1000, 4'b1000, 2'b11, 1'b1});

      // Instance B after a fresh reset, req=1001 held
      for (int k = 0; k < 6; k++) begin
`ifdef MUX_ARB_PRIO_EN
         tab_p.push_back('{4'b1001, 4'b0001, 2'b00, 1'b1});
`else
         if (k % 2 == 0) tab_p.push_back('{4'b1001, 4'b0001, 2'b00, 1'b1});
         else            tab_p.push_back('{4'b1001, 4'b1000, 2'b11, 1'b1});
`endif
      end

      rst_a = 1'b1; rst_b = 1'b1;
      req_a = '0;   req_b = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_a", {grant_a, s1_a, s0_a, busy_a}, 7'b0000_00_0);
      check("reset_b", {grant_b, s1_b, s0_b, busy_b}, 7'b0000_00_0);
      @(negedge clk);
      rst_a = 1'b0; rst_b = 1'b0;

      foreach (tab_a[i]) step_a(tab_a[i], $sformatf("tab_a[%0d]", i));

      // Owner 1 active: asynchronous reset mid-cycle
      #2 rst_a = 1'b1;
      #1 check("async_rst_own", {grant_a, s1_a, s0_a, busy_a}, 7'b0000_00_0);
      @(negedge clk);
      rst_a = 1'b0;
      step_a('{4'b1010, 4'b0010, 2'b01, 1'b1}, "post_rst_ptr3");
      step_a('{4'b0000, 4'b0000, 2'b01, 1'b1}, "post_rst_gap");
      // Reset during the gap
      #2 rst_a = 1'b1;
      #1 check("async_rst_gap", {grant_a, s1_a, s0_a, busy_a}, 7'b0000_00_0);
      @(negedge clk);
      rst_a = 1'b0;
      step_a('{4'b1000, 4'b1000, 2'b11, 1'b1}, "post_rst2");

      foreach (tab_b[i]) step_b(tab_b[i], $sformatf("tab_b[%0d]", i));

      @(negedge clk);
      rst_b = 1'b1;
      @(negedge clk);
      rst_b = 1'b0;
      foreach (tab_p[i]) step_b(tab_p[i], $sformatf("prio_1001[%0d]", i));

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
